// File: rtl/countdown_pkg.sv
// Shared types and seven-segment constants for the countdown BCD display path.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } disp_state_t;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-decimal
// nibbles blank the digit.
module bcd_to_7seg
    import countdown_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_bcd_display.sv
// Samples the countdown value, converts it to BCD with a one-step-per-cycle
// double-dabble engine and drives registered seven-segment digits.
module countdown_bcd_display
    import countdown_pkg::*;
#(
    parameter int N      = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          countdownIn,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic [7*DIGITS-1:0]   segOut,
    output logic                  busy,
    output logic                  valid
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);

    disp_state_t         state, nextState;
    logic [N-1:0]        shiftReg, lastSample;
    logic [SW-1:0]       scratch, scratchAdj;
    logic [CW-1:0]       stepCnt;
    logic                primed;
    logic                start;
    logic [7*DIGITS-1:0] segDec;

    // A conversion is always run once after reset, even if the input is zero
    assign start = (state == IDLE) && (!primed || (countdownIn != lastSample));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CONV;
            CONV:    if (stepCnt == CW'(1)) nextState = UPDATE;
            UPDATE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before the shift
    always_comb begin
        scratchAdj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                scratchAdj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg   <= '0;
            lastSample <= '0;
            scratch    <= '0;
            stepCnt    <= '0;
            primed     <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            bcdOut     <= '0;
            segOut     <= {DIGITS{SEG_BLANK}};
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg   <= countdownIn;
                        lastSample <= countdownIn;
                        scratch    <= '0;
                        primed     <= 1'b1;
                        busy       <= 1'b1;
                        stepCnt    <= CW'(N);
                    end
                end
                CONV: begin
                    scratch  <= {scratchAdj[SW-2:0], shiftReg[N-1]};
                    shiftReg <= {shiftReg[N-2:0], 1'b0};
                    stepCnt  <= stepCnt - CW'(1);
                end
                UPDATE: begin
                    bcdOut <= scratch;
                    segOut <= segDec;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : gDigit
        bcd_to_7seg uDec (
            .nibble (scratch[4*d +: 4]),
            .seg    (segDec[7*d +: 7])
        );
    end

endmodule

// File: doc/countdown_bcd_display.md
# countdown_bcd_display

Downstream consumer of the N-bit countdown counter. It samples the counter value and converts it to packed BCD digits using a sequential shift-add-3 (double-dabble) engine. It then drives active-low seven-segment patterns for each digit. It sits between the countdown counter and the board's HEX displays, and flags each completed update with a one-cycle `valid` pulse.

## Interface
- `N`, default 6: width of the incoming count. Legal range is 2..8.
- `DIGITS`, default 2: number of decimal digits produced. Must satisfy 10^DIGITS > 2^N − 1; use 3 when N is 7 or 8.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `countdownIn` input N: current countdown value, synchronous to `clk`.
- `bcdOut` output 4·DIGITS: packed BCD; digit 0 (units) is bits [3:0].
- `segOut` output 7·DIGITS: active-low segments. Digit d occupies [7d+6:7d], bit order g..a.
- `busy` output 1: high while a conversion is in flight.
- `valid` output 1: one-cycle pulse when `bcdOut` and `segOut` update.

## Operation
- **States:** IDLE, CONV, UPDATE.
- **Reset values:**
  - FSM enters IDLE; `bcdOut` = 0; `busy` = 0; `valid` = 0.
  - Every `segOut` digit = 7'b1111111, i.e. blank.
  - `lastSample` = 0; `primed` = 0.
- **IDLE:**
  - Starts a conversion when `primed` = 0, or when `countdownIn` ≠ `lastSample`.
  - On start: latch `countdownIn` into the shift register and into `lastSample`; clear the BCD scratch; set `primed` = 1 and `busy` = 1; load the step counter with N; go to CONV.
  - Otherwise hold all outputs.
- **CONV:** one double-dabble step per cycle.
  - First, add 3 to every scratch BCD nibble that is ≥ 5.
  - Then shift {scratch, binary} left by 1.
  - Decrement the step counter. After N steps, go to UPDATE.
- **UPDATE:**
  - Register scratch → `bcdOut`.
  - Register the decoded segments → `segOut`.
  - Assert `valid` for this cycle only; drop `busy` to 0; return to IDLE.
- **Segment encoding (active-low, g..a):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other nibble = 1111111.
- **Leading zeros:** displayed, not blanked.
- **Input change during CONV or UPDATE:** ignored while converting. On return to IDLE, the new value differs from `lastSample`, so a fresh conversion starts on the next edge. No value is lost if the input is stable for at least N+2 cycles.
- **Wrap-around (0 → 2^N−1):** treated as an ordinary change.
- **Width rule:** scratch is 4·DIGITS bits. Nibble adds never overflow for legal N/DIGITS pairs.

## Timing
- Let E0 be the edge on which IDLE detects a change and latches the input.
  - CONV steps occur on edges E1..EN.
  - Outputs update and `valid` rises on edge EN+1.
  - Latency from sampling edge to new outputs is N+1 cycles: 7 for N=6, 3 for N=2.
- `busy` is high from after E0 until EN+1, i.e. N+1 cycles.
- `valid` is never high in two consecutive cycles.
  - With a steadily changing input, the minimum spacing between pulses is N+2 cycles.
- After reset deasserts, the first conversion starts on the first edge, since `primed` = 0.
- `reset` asserted mid-conversion: state returns to the reset values asynchronously. The partial result is discarded and `valid` is not pulsed.

## Structure
- **Package `countdown_pkg`:**
  - FSM state enum `disp_state_t`.
  - The `SEG_*` digit-pattern constants.
  - `SEG_BLANK` = 7'b1111111.
- **Sub-module `bcd_to_7seg`:** combinational nibble → 7-bit decoder. Instantiate it DIGITS times under a generate loop.

## Test plan
- N=6, DIGITS=2, reset then hold 63:
  - `valid` pulses at the 7th edge after the first post-reset edge.
  - `bcdOut` = 8'h63, `segOut` = {0000010, 0110000}.
- N=6, step input 63 → 0 after the first update: the second `valid` gives `bcdOut` = 8'h00, `segOut` = {1000000, 1000000}.
- N=6, change 42 → 17 three cycles into a conversion:
  - The first `valid` yields 8'h42.
  - The next `valid` yields 8'h17, N+2 cycles later.
- N=6, assert `reset` at CONV step 3:
  - `busy` = 0, `bcdOut` = 0, all segments blank, no `valid`.
  - After release, value 25 yields 8'h25.
- N=2, DIGITS=2, inputs 3, 2, 1, 0 each held for 5 cycles: `bcdOut` = 8'h03, 8'h02, 8'h01, 8'h00, each latency 3.
- N=8, DIGITS=3, input 255: `bcdOut` = 12'h255 after 9 cycles; `segOut` digit 2 = 0100100.
